// File: rtl/crc_engine_param.sv
// Parametrised CRC generate/check engine: STEP dividend bits per cycle, two compile-time polynomials.
// Define CRC_ERR_CNT_EN to add the saturating 16-bit failed-check counter and its err_cnt port.
module crc_engine_param #(
    parameter int                 MSG_W      = 60,
    parameter int                 STEP       = 4,
    parameter int                 CRC_A_W    = 5,
    parameter logic [CRC_A_W-1:0] CRC_A_POLY = 5'h15,
    parameter int                 CRC_B_W    = 8,
    parameter logic [CRC_B_W-1:0] CRC_B_POLY = 8'hD5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             crc_sel,
    input  logic [MSG_W-1:0] message,
    output logic             in_ready,
    output logic             out_valid,
    output logic [MSG_W-1:0] out
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int N     = MSG_W / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [MSG_W-1:0] KEEP_A = {{(MSG_W-CRC_A_W){1'b1}}, {CRC_A_W{1'b0}}};
    localparam logic [MSG_W-1:0] KEEP_B = {{(MSG_W-CRC_B_W){1'b1}}, {CRC_B_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               mode_q;
    logic               sel_q;
    logic [MSG_W-1:0]   msg_q;
    logic [MSG_W-1:0]   dvd;
    logic [CRC_A_W-1:0] rem_a;
    logic [CRC_B_W-1:0] rem_b;
    logic               rem_fail;
    logic [MSG_W-1:0]   result;

    // Long division of the dividend: a generated codeword divides to zero on check.
    function automatic logic [CRC_A_W-1:0] div_a(input logic [CRC_A_W-1:0] rem,
                                                 input logic [STEP-1:0] bits);
        logic [CRC_A_W-1:0] r;
        logic               fb;
        r = rem;
        for (int i = STEP - 1; i >= 0; i--) begin
            fb = r[CRC_A_W-1];
            r  = {r[CRC_A_W-2:0], bits[i]} ^ (fb ? CRC_A_POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_B_W-1:0] div_b(input logic [CRC_B_W-1:0] rem,
                                                 input logic [STEP-1:0] bits);
        logic [CRC_B_W-1:0] r;
        logic               fb;
        r = rem;
        for (int i = STEP - 1; i >= 0; i--) begin
            fb = r[CRC_B_W-1];
            r  = {r[CRC_B_W-2:0], bits[i]} ^ (fb ? CRC_B_POLY : '0);
        end
        return r;
    endfunction

    // Datapath registers carry no reset; state decides when their contents matter.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            mode_q <= mode;
            sel_q  <= crc_sel;
            msg_q  <= message;
            dvd    <= mode ? message : (message & (crc_sel ? KEEP_B : KEEP_A));
            rem_a  <= '0;
            rem_b  <= '0;
        end else if (state == CALC) begin
            rem_a <= div_a(rem_a, dvd[MSG_W-1 -: STEP]);
            rem_b <= div_b(rem_b, dvd[MSG_W-1 -: STEP]);
            dvd   <= dvd << STEP;
        end
    end

    always_comb begin
        rem_fail = sel_q ? (|rem_b) : (|rem_a);
        result   = '0;
        if (!mode_q) begin
            result = sel_q ? ((msg_q & KEEP_B) | MSG_W'(rem_b))
                           : ((msg_q & KEEP_A) | MSG_W'(rem_a));
        end else if (rem_fail) begin
            result = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
`ifdef CRC_ERR_CNT_EN
            err_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= CALC;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out       <= result;
                    out_valid <= 1'b1;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
`ifdef CRC_ERR_CNT_EN
                    if (mode_q && rem_fail && err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine_param.sv
// Scoreboard bench for crc_engine_param: four engines with STEP = 1, 4, 12, 60 share the message inputs.
module tb_crc_engine_param;

    typedef struct {
        logic [59:0] data;
        int          acc;
        logic [3:0]  lanes;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  iv  = '0;
    logic        mode = 1'b0;
    logic        sel  = 1'b0;
    logic [59:0] msg  = '0;
    logic [3:0]  ir;
    logic [3:0]  ov;
    logic [59:0] od [4];
`ifdef CRC_ERR_CNT_EN
    logic [15:0] ec [4];
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   sent [4] = '{0, 0, 0, 0};
    int   err1  = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 12 : 60;
        localparam int LN = 60 / ST;
        int rd  = 0;
        int got = 0;

        crc_engine_param #(.STEP(ST)) dut (
`ifdef CRC_ERR_CNT_EN
            .err_cnt  (ec[g]),
`endif
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .mode     (mode),
            .crc_sel  (sel),
            .message  (msg),
            .in_ready (ir[g]),
            .out_valid(ov[g]),
            .out      (od[g])
        );

        always @(negedge clk) begin
            if (!rst && ov[g]) begin
                while (rd < exp_q.size() && !exp_q[rd].lanes[g]) rd++;
                n_vec++;
                if (rd >= exp_q.size()) begin
                    n_err++;
                    $display("FAIL unexpected_out lane%0d: out=%h, no request outstanding", g, od[g]);
                end else begin
                    if (od[g] !== exp_q[rd].data) begin
                        n_err++;
                        $display("FAIL vec%0d lane%0d data: got %h want %h", exp_q[rd].tag, g, od[g], exp_q[rd].data);
                    end
                    n_vec++;
                    if (cyc - exp_q[rd].acc - 1 != LN + 1) begin
                        n_err++;
                        $display("FAIL vec%0d lane%0d latency: got %0d want %0d", exp_q[rd].tag, g,
                                 cyc - exp_q[rd].acc - 1, LN + 1);
                    end
                    rd++;
                    got++;
                end
            end
        end
    end

    function automatic logic [59:0] model(input logic md, input logic s, input logic [59:0] m);
        int          w;
        logic [59:0] p, d, keep;
        w    = s ? 8 : 5;
        p    = s ? 60'h1D5 : 60'h35;
        keep = ~((60'd1 << w) - 60'd1);
        d    = md ? m : (m & keep);
        for (int i = 59; i >= w; i--) begin
            if (d[i]) d = d ^ (p << (i - w));
        end
        if (!md) return (m & keep) | d;
        return (d == 60'd0) ? '0 : '1;
    endfunction

    function automatic int got_of(input int g);
        case (g)
            0: return lane[0].got;
            1: return lane[1].got;
            2: return lane[2].got;
            default: return lane[3].got;
        endcase
    endfunction

    task automatic send(input logic [3:0] lanes, input logic md, input logic s,
                        input logic [59:0] m, input logic [59:0] want, input int tag, input bit track);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (((ir & lanes) != lanes) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL vec%0d accept_timeout: in_ready=%b need %b", tag, ir, lanes);
            return;
        end
        mode = md;
        sel  = s;
        msg  = m;
        iv   = lanes;
        if (track) begin
            e.data  = want;
            e.acc   = cyc;
            e.lanes = lanes;
            e.tag   = tag;
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) if (lanes[i]) sent[i]++;
        end
        @(negedge clk);
        iv = '0;
    endtask

    task automatic drain();
        int t;
        int pend;
        t = 0;
        while (t < 400) begin
            pend = 0;
            for (int i = 0; i < 4; i++) pend += sent[i] - got_of(i);
            if (pend == 0) break;
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [63:0] r;
        logic [59:0] m, want;
        logic        md, s;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (ir !== 4'hF || ov !== 4'h0 || od[1] !== 60'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc%0d: in_ready=%b out_valid=%b out=%h want 1111/0000/0", i, ir, ov, od[1]);
            end
`ifdef CRC_ERR_CNT_EN
            n_vec++;
            if (ec[1] !== 16'd0) begin
                n_err++;
                $display("FAIL reset_idle err_cnt: got %0d want 0", ec[1]);
            end
`endif
        end

        send(4'b0010, 1'b0, 1'b1, 60'h100, 60'h1D5, 1, 1'b1);
        drain();
        send(4'b0010, 1'b0, 1'b0, 60'h20, 60'h35, 2, 1'b1);
        drain();
        send(4'b0010, 1'b1, 1'b1, 60'h1D5, 60'h0, 3, 1'b1);
        drain();
        send(4'b0010, 1'b1, 1'b1, 60'h1D4, 60'hFFF_FFFF_FFFF_FFFF, 4, 1'b1);
        drain();
        err1 = 1;
`ifdef CRC_ERR_CNT_EN
        n_vec++;
        if (ec[1] !== 16'(err1)) begin
            n_err++;
            $display("FAIL err_cnt_after_fail: got %0d want %0d", ec[1], err1);
        end
`endif
        send(4'b0010, 1'b1, 1'b0, 60'h35, 60'h0, 5, 1'b1);
        drain();

        // Busy: extra request and changed inputs during CALC must be ignored.
        send(4'b0010, 1'b0, 1'b0, 60'h20, 60'h35, 6, 1'b1);
        repeat (3) @(negedge clk);
        iv   = 4'b0010;
        mode = 1'b0;
        sel  = 1'b1;
        msg  = 60'h100;
        repeat (3) @(negedge clk);
        iv = '0;
        drain();

        // Abort: reset during CALC step 7, then a clean message.
        send(4'b0010, 1'b1, 1'b1, 60'h1D4, 60'h0, 7, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err1 = 0;
        n_vec++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || od[1] !== 60'd0) begin
            n_err++;
            $display("FAIL mid_calc_reset: in_ready=%b out_valid=%b out=%h want 1/0/0", ir[1], ov[1], od[1]);
        end
`ifdef CRC_ERR_CNT_EN
        n_vec++;
        if (ec[1] !== 16'd0) begin
            n_err++;
            $display("FAIL mid_calc_reset err_cnt: got %0d want 0", ec[1]);
        end
`endif
        repeat (20) @(negedge clk);
        send(4'b0010, 1'b0, 1'b1, 60'h100, 60'h1D5, 8, 1'b1);
        drain();

        // STEP sweep against the bitwise model.
        for (int k = 0; k < 12; k++) begin
            r  = {$urandom(), $urandom()};
            m  = r[59:0];
            md = k[0];
            s  = k[1];
            if (md && k[2]) m = model(1'b0, s, m);
            want = model(md, s, m);
            if (md && want != 60'd0) err1++;
            send(4'hF, md, s, m, want, 100 + k, 1'b1);
        end
        drain();
`ifdef CRC_ERR_CNT_EN
        n_vec++;
        if (ec[1] !== 16'(err1)) begin
            n_err++;
            $display("FAIL err_cnt_sweep: got %0d want %0d", ec[1], err1);
        end
`endif

        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (got_of(i) != sent[i]) begin
                n_err++;
                $display("FAIL outputs_lane%0d: got %0d results want %0d", i, got_of(i), sent[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
